// File: rtl/inst_rom_loader.sv
// Instruction ROM fed by a byte-wide boot load stream, then read combinationally by the core.
// Latency: load bytes land in storage on the accepting edge; fetch reads are zero-latency.
// Backpressure: ld_ready_o is high for the whole LOAD phase and low once the image is in (RUN).
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  input  logic                  ld_restart_i,
  output logic                  cpu_rst_o,
  output logic                  ld_err_o,
  output logic [ADDR_WIDTH:0]   words_loaded_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH:0] TOP_PTR = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  logic [0:0]            state;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH:0]   word_ptr;
  // Upper three bytes of the word being assembled; the fourth byte is taken
  // straight from the input on the completing accept.
  logic [23:0]           asm_word;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  word_done;
  logic                  at_top;
  logic [31:0]           next_word;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  addr_ok;
  logic [1:0]            unused_addr_lsb;

  assign ld_ready_o     = (state == ST_LOAD);
  assign accept         = ld_valid_i && ld_ready_o;
  assign word_done      = accept && ((byte_cnt == 2'd3) || ld_last_i);
  assign at_top         = (word_ptr == TOP_PTR);
  assign words_loaded_o = word_ptr;

  // Merge the incoming byte into its big-endian lane; lanes below it are zero,
  // which gives the zero padding for a short final word for free.
  always_comb begin
    next_word = 32'h0;
    case (byte_cnt)
      2'd0:    next_word = {ld_data_i, 24'h0};
      2'd1:    next_word = {asm_word[23:16], ld_data_i, 16'h0};
      2'd2:    next_word = {asm_word[23:8], ld_data_i, 8'h0};
      default: next_word = {asm_word, ld_data_i};
    endcase
  end

  // Load/run control: byte packing, word pointer, core reset and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      byte_cnt  <= 2'd0;
      word_ptr  <= '0;
      asm_word  <= 24'h0;
      cpu_rst_o <= 1'b1;
      ld_err_o  <= 1'b0;
    end else if (state == ST_LOAD) begin
      if (accept) begin
        if (word_done) begin
          byte_cnt <= 2'd0;
          asm_word <= 24'h0;
          word_ptr <= word_ptr + PTR_ONE;
          // Either the image ended or storage is full; a full store without
          // the last marker means the image was truncated.
          if (ld_last_i || at_top) begin
            state     <= ST_RUN;
            cpu_rst_o <= 1'b0;
            ld_err_o  <= !ld_last_i;
          end
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_word <= next_word[31:8];
        end
      end
    end else begin
      if (ld_restart_i) begin
        state     <= ST_LOAD;
        byte_cnt  <= 2'd0;
        word_ptr  <= '0;
        asm_word  <= 24'h0;
        cpu_rst_o <= 1'b1;
        ld_err_o  <= 1'b0;
      end
    end
  end

  // Word storage; never cleared, and a reset edge suppresses a coincident write
  // so a load interrupted by reset leaves no partial word behind.
  always_ff @(posedge clk) begin
    if (!rst && word_done) begin
      mem[word_ptr[ADDR_WIDTH-1:0]] <= next_word;
    end
  end

  assign rd_idx          = rom_addr_i[ADDR_WIDTH+1:2];
  assign addr_ok         = (rom_addr_i[31:ADDR_WIDTH+2] == '0);
  // Byte offset within a word is irrelevant: fetches are always whole words.
  assign unused_addr_lsb = rom_addr_i[1:0];

  // Fetch path: only a qualified, in-range fetch while running sees storage.
  always_comb begin
    rom_data_o = 32'h0;
    if ((state == ST_RUN) && rom_ce_i && addr_ok) begin
      rom_data_o = mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: a wide instance (ADDR_WIDTH=10) and a tiny one (ADDR_WIDTH=2)
// for overflow. Stimulus pushes expected fetch data into per-instance queues; a negedge
// monitor pops/compares fetch results and checks status outputs against a byte-level model.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v = 2'b11;
  logic [1:0]  ce_v = 2'b00;
  logic [1:0]  vld_v = 2'b00;
  logic [1:0]  last_v = 2'b00;
  logic [1:0]  rs_v = 2'b00;
  logic [1:0]  fv = 2'b00;
  logic [31:0] addr_v [2];
  logic [7:0]  dat_v [2];

  logic [31:0] data0, data1;
  logic [1:0]  rdy_v, crst_v, err_v;
  logic [10:0] wl0;
  logic [2:0]  wl1;

  inst_rom_loader #(.ADDR_WIDTH(10)) dut0 (
    .clk(clk), .rst(rst_v[0]), .rom_ce_i(ce_v[0]), .rom_addr_i(addr_v[0]),
    .rom_data_o(data0), .ld_valid_i(vld_v[0]), .ld_data_i(dat_v[0]),
    .ld_last_i(last_v[0]), .ld_ready_o(rdy_v[0]), .ld_restart_i(rs_v[0]),
    .cpu_rst_o(crst_v[0]), .ld_err_o(err_v[0]), .words_loaded_o(wl0)
  );

  inst_rom_loader #(.ADDR_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst_v[1]), .rom_ce_i(ce_v[1]), .rom_addr_i(addr_v[1]),
    .rom_data_o(data1), .ld_valid_i(vld_v[1]), .ld_data_i(dat_v[1]),
    .ld_last_i(last_v[1]), .ld_ready_o(rdy_v[1]), .ld_restart_i(rs_v[1]),
    .cpu_rst_o(crst_v[1]), .ld_err_o(err_v[1]), .words_loaded_o(wl1)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  // Reference model: image as a sequence of accepted bytes grouped into words.
  bit          m_run [2];
  bit          m_err [2];
  int          m_n [2];
  int          m_words [2];
  logic [31:0] m_cur [2];
  logic [31:0] m_mem [2][1024];
  bit          m_wr [2][1024];

  function automatic int aw_of(int i);
    return (i == 0) ? 10 : 2;
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset_load(int i);
    m_run[i] = 1'b0; m_err[i] = 1'b0; m_n[i] = 0; m_words[i] = 0; m_cur[i] = 32'h0;
  endfunction

  function automatic void model_step(int i);
    int depth = 1 << aw_of(i);
    if (rst_v[i]) begin
      model_reset_load(i);
    end else if (m_run[i]) begin
      if (rs_v[i]) model_reset_load(i);
    end else if (vld_v[i]) begin
      m_cur[i] = m_cur[i] | (32'(dat_v[i]) << (24 - 8 * (m_n[i] % 4)));
      m_n[i]++;
      if ((m_n[i] % 4 == 0) || last_v[i]) begin
        m_mem[i][m_words[i]] = m_cur[i];
        m_wr[i][m_words[i]] = 1'b1;
        m_cur[i] = 32'h0;
        m_words[i]++;
        if (last_v[i]) begin
          m_run[i] = 1'b1;
        end else if (m_words[i] == depth) begin
          m_run[i] = 1'b1;
          m_err[i] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [31:0] model_read(int i, logic c, logic [31:0] a);
    int aw = aw_of(i);
    if (!m_run[i] || !c) return 32'h0;
    if ((a >> (aw + 2)) != 0) return 32'h0;
    return m_mem[i][(a >> 2) & ((1 << aw) - 1)];
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Monitor: fetch results against the scoreboard, status against the model.
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        check(i == 0 ? "cpu_rst0" : "cpu_rst1", 64'(crst_v[i]), 64'(!m_run[i]));
        check(i == 0 ? "ready0" : "ready1", 64'(rdy_v[i]), 64'(!m_run[i]));
        check(i == 0 ? "err0" : "err1", 64'(err_v[i]), 64'(m_err[i]));
      end
      check("words0", 64'(wl0), 64'(m_words[0]));
      check("words1", 64'(wl1), 64'(m_words[1]));
      if (fv[0]) begin
        if (q0.size() == 0) check("fetch0 no expectation", 64'(data0), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin e = q0.pop_front(); check("fetch0", 64'(data0), 64'(e)); end
      end
      if (fv[1]) begin
        if (q1.size() == 0) check("fetch1 no expectation", 64'(data1), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin e = q1.pop_front(); check("fetch1", 64'(data1), 64'(e)); end
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input int i, input logic [7:0] b, input logic l);
    vld_v[i] = 1'b1; dat_v[i] = b; last_v[i] = l;
    @(posedge clk); #1;
    vld_v[i] = 1'b0; last_v[i] = 1'b0; dat_v[i] = 8'h0;
  endtask

  task automatic pulse_restart(input int i);
    rs_v[i] = 1'b1; @(posedge clk); #1; rs_v[i] = 1'b0;
  endtask

  task automatic pulse_rst(input int i);
    rst_v[i] = 1'b1; @(posedge clk); #1; rst_v[i] = 1'b0;
  endtask

  task automatic fetch_c(input int i, input logic [31:0] a, input logic c, input logic [31:0] exp);
    addr_v[i] = a; ce_v[i] = c; fv[i] = 1'b1;
    if (i == 0) q0.push_back(exp); else q1.push_back(exp);
    @(posedge clk); #1;
    fv[i] = 1'b0; ce_v[i] = 1'b0; addr_v[i] = 32'h0;
  endtask

  task automatic rand_fetch(input int i);
    int aw = aw_of(i);
    int idx = int'($urandom_range(0, (1 << aw) - 1));
    logic [31:0] a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
    logic c = m_wr[i][idx] ? ($urandom_range(0, 4) != 0) : 1'b0;
    if ($urandom_range(0, 3) == 0) a = a | (32'd1 << (aw + 2 + int'($urandom_range(0, 29 - aw))));
    fetch_c(i, a, c, model_read(i, c, a));
  endtask

  initial begin
    logic [7:0] img [8];
    img[0] = 8'h34; img[1] = 8'h01; img[2] = 8'h11; img[3] = 8'h00;
    img[4] = 8'h34; img[5] = 8'h02; img[6] = 8'h00; img[7] = 8'h20;
    addr_v[0] = 32'h0; addr_v[1] = 32'h0; dat_v[0] = 8'h0; dat_v[1] = 8'h0;
    for (int i = 0; i < 2; i++) begin
      model_reset_load(i);
      for (int k = 0; k < 1024; k++) begin m_wr[i][k] = 1'b0; m_mem[i][k] = 32'h0; end
    end
    repeat (2) @(posedge clk);
    #1; rst_v = 2'b00;
    check("reset cpu_rst0", 64'(crst_v[0]), 64'd1);
    check("reset ready0", 64'(rdy_v[0]), 64'd1);
    check("reset words0", 64'(wl0), 64'd0);
    mon_en = 1'b1;

    // Normal load with a two-cycle gap after the third byte.
    for (int k = 0; k < 8; k++) begin
      if (k == 3) idle(2);
      if (k == 7) check("cpu_rst before last", 64'(crst_v[0]), 64'd1);
      send_byte(0, img[k], k == 7);
    end
    check("cpu_rst after last", 64'(crst_v[0]), 64'd0);
    check("normal words", 64'(wl0), 64'd2);
    check("normal err", 64'(err_v[0]), 64'd0);
    fetch_c(0, 32'h0, 1'b1, 32'h3401_1100);
    fetch_c(0, 32'h4, 1'b1, 32'h3402_0020);
    fetch_c(0, 32'h5, 1'b1, 32'h3402_0020);
    // Gating.
    fetch_c(0, 32'h0, 1'b0, 32'h0);
    fetch_c(0, 32'h0000_1000, 1'b1, 32'h0);

    // Restart back into LOAD; fetches are blanked while loading.
    pulse_restart(0);
    check("restart cpu_rst", 64'(crst_v[0]), 64'd1);
    check("restart ready", 64'(rdy_v[0]), 64'd1);
    check("restart words", 64'(wl0), 64'd0);
    fetch_c(0, 32'h0, 1'b1, 32'h0);
    fetch_c(0, 32'h4, 1'b1, 32'h0);

    // Partial final word is zero padded.
    send_byte(0, 8'h11, 1'b0); send_byte(0, 8'h22, 1'b0); send_byte(0, 8'h33, 1'b0);
    send_byte(0, 8'h44, 1'b0); send_byte(0, 8'hAB, 1'b1);
    check("partial words", 64'(wl0), 64'd2);
    fetch_c(0, 32'h0, 1'b1, 32'h1122_3344);
    fetch_c(0, 32'h4, 1'b1, 32'hAB00_0000);

    // Reset in the middle of a load.
    pulse_restart(0);
    for (int k = 0; k < 6; k++) send_byte(0, 8'(8'h60 + k), 1'b0);
    pulse_rst(0);
    check("midrst cpu_rst", 64'(crst_v[0]), 64'd1);
    check("midrst words", 64'(wl0), 64'd0);
    send_byte(0, 8'hDE, 1'b0); send_byte(0, 8'hAD, 1'b0);
    send_byte(0, 8'hBE, 1'b0); send_byte(0, 8'hEF, 1'b1);
    check("midrst words after", 64'(wl0), 64'd1);
    fetch_c(0, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // Overflow on the four-word instance.
    for (int k = 1; k <= 16; k++) send_byte(1, 8'(k), 1'b0);
    check("ovf err", 64'(err_v[1]), 64'd1);
    check("ovf ready", 64'(rdy_v[1]), 64'd0);
    check("ovf words", 64'(wl1), 64'd4);
    check("ovf cpu_rst", 64'(crst_v[1]), 64'd0);
    send_byte(1, 8'd17, 1'b0);
    check("ovf words after 17th", 64'(wl1), 64'd4);
    fetch_c(1, 32'hC, 1'b1, 32'h0D0E_0F10);
    fetch_c(1, 32'h0, 1'b1, 32'h0102_0304);
    fetch_c(1, 32'h10, 1'b1, 32'h0);
    // Filling exactly with last on the final byte is not an error.
    pulse_restart(1);
    check("restart err1", 64'(err_v[1]), 64'd0);
    for (int k = 1; k <= 16; k++) send_byte(1, 8'(8'h80 + k), k == 16);
    check("exact fill err", 64'(err_v[1]), 64'd0);
    check("exact fill words", 64'(wl1), 64'd4);
    fetch_c(1, 32'hD, 1'b1, 32'h8D8E_8F90);

    // Randomized images and fetches on both instances.
    for (int r = 0; r < 6; r++) begin
      int len;
      pulse_restart(0);
      len = int'($urandom_range(1, 24));
      for (int k = 0; k < len; k++) begin
        idle(int'($urandom_range(0, 2)));
        send_byte(0, 8'($urandom), k == len - 1);
      end
      for (int k = 0; k < 6; k++) rand_fetch(0);
    end
    for (int r = 0; r < 8; r++) begin
      int len;
      bit use_last;
      pulse_rst(1);
      len = int'($urandom_range(1, 20));
      use_last = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < len; k++) begin
        idle(int'($urandom_range(0, 1)));
        send_byte(1, 8'($urandom), use_last && (k == len - 1));
      end
      for (int k = 0; k < 5; k++) rand_fetch(1);
      pulse_restart(1);
      rand_fetch(1);
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder for the CPU core's fetch port. It is the other end of the `rom_ce`/`rom_addr`/`rom_data` interface.
- After reset, a byte-wide valid/ready load stream fills internal word storage. The core is held in reset during the load.
- Once loading completes, the block serves 32-bit instruction words to the core by combinational read.
- Sits at SoC top level, beside the core, between the boot loader source (UART/JTAG bridge) and the core.

Parameters:
- ADDR_WIDTH, 10, word-address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rom_ce_i  input  1  fetch enable from core.
- rom_addr_i  input  32  fetch byte address from core.
- rom_data_o  output  32  instruction word to core.
- ld_valid_i  input  1  load byte valid.
- ld_data_i  input  8  load byte.
- ld_last_i  input  1  marks final byte of image; qualified by ld_valid_i.
- ld_ready_o  output  1  loader can accept a byte.
- ld_restart_i  input  1  one-cycle pulse; in RUN, restarts loading.
- cpu_rst_o  output  1  reset to core, active high, registered.
- ld_err_o  output  1  sticky overflow flag, registered.
- words_loaded_o  output  ADDR_WIDTH+1  number of words written in the current load.

Behaviour:
Reset:
- One clock and one reset only; reset is synchronous and active-high.
- When rst=1 at a clock edge: state<=LOAD, byte_cnt<=0, word_ptr<=0, assembly register<=0, cpu_rst_o<=1, ld_err_o<=0, words_loaded_o<=0.
- Storage contents are not cleared.
- rst mid-load discards the partial word and restarts at word 0.

States:
- LOAD: ld_ready_o=1, rom_data_o=0.
- RUN: ld_ready_o=0.
- ld_ready_o is a decode of state (combinational from state).

Byte acceptance (LOAD only):
- A byte is accepted when ld_valid_i && ld_ready_o. Gaps (valid low) are allowed with no effect.
- Packing is big-endian: byte_cnt 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
- On the accept with byte_cnt==3: write the assembled word to mem[word_ptr], word_ptr<=word_ptr+1, byte_cnt<=0.
- Otherwise byte_cnt<=byte_cnt+1.
- The word write and the counter update happen at the same edge as the accept.

Last byte:
- An accept with ld_last_i=1 and byte_cnt<3 zero-pads the remaining lower bytes and writes the partial word anyway. word_ptr increments.
- On the same edge: state<=RUN, cpu_rst_o<=0.
- The core therefore leaves reset one cycle after the last byte is accepted.

Overflow:
- When the word written is at word_ptr==DEPTH-1 and ld_last_i=0: the word is written, state<=RUN, cpu_rst_o<=0, ld_err_o<=1.
- The image is truncated; further bytes see ld_ready_o=0.
- If ld_last_i=1 on that byte, there is no error.

words_loaded_o:
- Equals word_ptr.
- Range 0..DEPTH.
- Holds its value in RUN.

Restart:
- ld_restart_i=1 in RUN: state<=LOAD, cpu_rst_o<=1, byte_cnt<=0, word_ptr<=0, ld_err_o<=0.
- Ignored in LOAD.
- rst has priority over ld_restart_i.

Read path (combinational, zero latency, so the core's fetch stage latches data the same cycle the address is presented):
- rom_data_o = mem[rom_addr_i[ADDR_WIDTH+1:2]] only when state==RUN, rom_ce_i=1, and rom_addr_i[31:ADDR_WIDTH+2]==0.
- Otherwise rom_data_o = 0.
- rom_addr_i[1:0] is ignored.
- No read-during-write hazard exists: writes occur only in LOAD, reads only in RUN.

Test Plan:
- Normal load: after rst, feed 0x34,0x01,0x11,0x00,0x34,0x02,0x00,0x20 with last on the 8th byte, valid low 2 cycles between bytes 3 and 4.
  -> cpu_rst_o falls one cycle after the 8th accept; words_loaded_o=2; ld_err_o=0.
  -> addr 0x0 with ce=1 gives 0x34011100; addr 0x4 gives 0x34020020; addr 0x5 gives 0x34020020.
- Partial word: 5 bytes 0x11,0x22,0x33,0x44,0xAB, last on 0xAB.
  -> word0=0x11223344, word1=0xAB000000, words_loaded_o=2.
- Gating: in RUN, ce=0 at addr 0 -> 0. With ADDR_WIDTH=10, addr 0x00001000 and ce=1 -> 0. During LOAD with ce=1, any addr -> 0.
- Overflow: ADDR_WIDTH=2, 17 bytes with no last.
  -> after the 16th accept: RUN, ld_err_o=1, words_loaded_o=4, ld_ready_o=0; 17th byte not accepted; word3 readable at addr 0xC.
- Reset mid-load: 6 bytes, then rst one cycle, then 4 bytes 0xDE,0xAD,0xBE,0xEF with last.
  -> word0=0xDEADBEEF, words_loaded_o=1, cpu_rst_o=1 throughout until the final accept.
- Restart: in RUN, pulse ld_restart_i.
  -> next cycle cpu_rst_o=1, ld_ready_o=1, words_loaded_o=0, ld_err_o=0; a new 4-byte image loads to word 0.
